// File: rtl/uart_rx_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_word_packer
// Purpose  : Packs UART bytes little-endian into 32-bit words behind a FWFT
//            FIFO with sticky overflow / framing-error flags.
//            Optional macro UART_WORD_TIMEOUT_EN drops stale partial words.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_word_packer #(
  parameter int DEPTH_LOG2   = 4,
  parameter int TIMEOUT_CLKS = 100000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx_ready,
  input  logic [7:0]            rx_data,
  input  logic                  rx_ferr,
  output logic                  word_valid,
  output logic [31:0]           word_data,
  input  logic                  word_ready,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow,
  output logic                  ferr
);

  localparam int c_DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]           r_mem [c_DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [1:0]            r_byte_cnt;
  logic [23:0]           r_asm;
  logic                  r_overflow;
  logic                  r_ferr;

  logic       w_timeout;
  logic [1:0] w_cnt;
  logic       w_accept;
  logic       w_complete;
  logic       w_pop;
  logic       w_full;
  logic       w_push;

`ifdef UART_WORD_TIMEOUT_EN
  logic [31:0] r_idle;

  assign w_timeout = (r_byte_cnt != 2'd0) && (r_idle == 32'(TIMEOUT_CLKS));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_idle <= 32'd0;
    end else if (w_accept || w_timeout || rx_ferr) begin
      r_idle <= 32'd0;
    end else if (r_byte_cnt != 2'd0) begin
      r_idle <= r_idle + 32'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // A byte landing on the timeout cycle starts a fresh word.
  assign w_cnt      = w_timeout ? 2'd0 : r_byte_cnt;
  assign w_accept   = rx_ready && !rx_ferr && !r_ferr;
  assign w_complete = w_accept && (w_cnt == 2'd3);
  assign w_pop      = (r_count != '0) && word_ready;
  assign w_full     = (r_count == (DEPTH_LOG2+1)'(c_DEPTH));
  assign w_push     = w_complete && (!w_full || w_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_byte_cnt <= 2'd0;
      r_asm      <= 24'd0;
      r_ferr     <= 1'b0;
    end else if (rx_ferr) begin
      r_ferr     <= 1'b1;
      r_byte_cnt <= 2'd0;
      r_asm      <= 24'd0;
    end else if (w_accept) begin
      r_byte_cnt <= w_cnt + 2'd1;
      if (w_cnt == 2'd3) begin
        r_asm <= 24'd0;
      end else begin
        r_asm[{w_cnt, 3'b000} +: 8] <= rx_data;
      end
    end else if (w_timeout) begin
      r_byte_cnt <= 2'd0;
      r_asm      <= 24'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + (DEPTH_LOG2+1)'(w_push) - (DEPTH_LOG2+1)'(w_pop);
      if (w_complete && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage has no reset; validity is tracked by r_count alone.
  always_ff @(posedge clock) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr] <= {rx_data, r_asm};
    end
  end

  assign word_valid = (r_count != '0);
  assign word_data  = r_mem[r_rd_ptr];
  assign fifo_count = r_count;
  assign overflow   = r_overflow;
  assign ferr       = r_ferr;

endmodule
`default_nettype wire
